// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core. One round per clock. The round key is
// expanded on the fly from the previous round key. A start/busy/done
// handshake frames each 10-round run.
// Byte 15 of every 128-bit block is the first FIPS-197 byte. In the flat
// [127:0] view, FIPS byte i occupies bits [127-8*i -: 8].
module aes_enc_iter #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0][7:0] din,
    input  logic [15:0][7:0] key,
    output logic             busy,
    output logic             done,
    output logic [15:0][7:0] dout
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q, key_q, dout_q;
    logic         busy_q, done_q;

    logic [127:0] sb_w, sr_w, mc_w, rk_d, round_d, final_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] substitute(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sub_byte(s[8*i +: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3, t;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            o[127-32*c -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            o[119-32*c -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            o[111-32*c -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            o[103-32*c -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key from the current one: w0 ^= SubWord(RotWord(w3)) ^ Rcon,
    // and each following word chains on the one before it.
    function automatic logic [127:0] keyexpand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sub_byte(k[23:16]), sub_byte(k[15:8]), sub_byte(k[7:0]), sub_byte(k[31:24])}
             ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign sb_w    = substitute(state_q);
    assign sr_w    = shiftrows(sb_w);
    assign mc_w    = mixcolumns(sr_w);
    assign rk_d    = keyexpand(key_q, rcon(rnd_q));
    assign round_d = mc_w ^ rk_d;
    assign final_d = sr_w ^ rk_d;

    // Control FSM, round counter and data registers. The final round also
    // stores its round key, so key_q holds round key 10 after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= din ^ key;
                        key_q   <= key;
                        rnd_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    if (rnd_q == 4'd0 || rnd_q > NR_L) begin
                        // Unreachable counter values fall back to IDLE.
                        fsm_q  <= IDLE;
                        rnd_q  <= 4'd0;
                        busy_q <= 1'b0;
                    end else if (rnd_q == NR_L) begin
                        dout_q <= final_d;
                        key_q  <= rk_d;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        rnd_q  <= 4'd0;
                        fsm_q  <= IDLE;
                    end else begin
                        state_q <= round_d;
                        key_q   <= rk_d;
                        rnd_q   <= rnd_q + 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: FIPS-197 vectors from a table,
// handshake corner cases, and random blocks checked against a byte-level
// reference model plus its inverse cipher.
module tb_aes_enc_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_s = 1'b0;
    logic [127:0] din_s = '0;
    logic [127:0] key_s = '0;
    logic         busy, done;
    logic [127:0] dout;

    aes_enc_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .din   (din_s),
        .key   (key_s),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] BK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BD = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BE = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CD = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CE = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BRK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0] k;
        logic [127:0] d;
        logic [127:0] e;
    } vec_t;

    vec_t         vt [3];
    logic [127:0] sb_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    logic [7:0] ks_m  [176];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box built by walking generator 3 and its inverse in lockstep.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    task automatic key_sched(input logic [127:0] k);
        logic [7:0] t4 [4];
        logic [7:0] rc, tmp;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) ks_m[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t4[j] = ks_m[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp   = t4[0];
                t4[0] = sbox[t4[1]] ^ rc;
                t4[1] = sbox[t4[2]];
                t4[2] = sbox[t4[3]];
                t4[3] = sbox[tmp];
                rc    = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            for (int j = 0; j < 4; j++) ks_m[4*i+j] = ks_m[4*(i-4)+j] ^ t4[j];
        end
    endtask

    task automatic model_enc(input logic [127:0] k, input logic [127:0] d, output logic [127:0] o);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        key_sched(k);
        for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8] ^ ks_m[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ ks_m[16*r+i];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    endtask

    task automatic model_dec(input logic [127:0] k, input logic [127:0] ct, output logic [127:0] o);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        key_sched(k);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks_m[160+i];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*((c+w)%4)] = s[w+4*c];
            for (int i = 0; i < 16; i++) t[i] = isbox[t[i]] ^ ks_m[16*r+i];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                    s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                    s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                    s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                end
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    endtask

    // Called just after a falling edge; the block is accepted at the next rising edge.
    task automatic launch(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e);
        key_s   = k;
        din_s   = d;
        start_s = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start_s = 1'b0;
        din_s   = ~d;
        key_s   = ~k;
    endtask

    task automatic pop_check(input string nm);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: done with empty scoreboard, dout %h", nm, dout);
        end else begin
            chk(nm, dout, sb_q.pop_front());
        end
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input int exp_busy);
        int cyc, bcnt;
        bit got;
        cyc = 0; bcnt = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done within %0d cycles, expected after %0d", nm, cyc, exp_lat);
        end else begin
            chk_int({nm, " latency"}, cyc, exp_lat);
            chk_int({nm, " busy cycles"}, bcnt, exp_busy);
            pop_check({nm, " dout"});
        end
    endtask

    initial begin
        logic [127:0] k, d, e, rt, first;
        int cyc, cnt, bcnt, unstable;
        bit got;

        build_tables();
        vt[0] = '{k: BK, d: BD, e: BE};
        vt[1] = '{k: CK, d: CD, e: CE};
        vt[2] = '{k: '0, d: '0, e: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset busy", {127'd0, busy}, '0);
        chk("reset done", {127'd0, done}, '0);
        chk("reset dout", dout, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors.
        for (int i = 0; i < 3; i++) begin
            launch(vt[i].k, vt[i].d, vt[i].e);
            wait_done($sformatf("vec%0d", i), 11, 10);
            if (i == 0) chk("B round-10 key reg", dut.key_q, BRK10);
            @(negedge clk);
            chk_int($sformatf("vec%0d done pulse width", i), int'(done), 0);
            chk($sformatf("vec%0d dout held", i), dout, vt[i].e);
        end

        // start mid-run is ignored.
        launch(CK, CD, CE);
        repeat (4) @(negedge clk);
        key_s = BK; din_s = BD; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_done("midrun start", 6, 5);
        cnt = 0; bcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
            if (busy) bcnt++;
        end
        chk_int("midrun extra done", cnt, 0);
        chk_int("midrun extra busy", bcnt, 0);

        // start held high: back-to-back runs with inputs switched in the done cycle.
        key_s = CK; din_s = CD; start_s = 1'b1;
        sb_q.push_back(CE);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL b2b first timeout: no done within %0d cycles", cyc);
        end else begin
            pop_check("b2b first dout");
        end
        key_s = BK; din_s = BD;
        sb_q.push_back(BE);
        first = dout;
        cyc = 0; got = 1'b0; unstable = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (dout !== first) unstable++;
        end
        start_s = 1'b0;
        chk_int("b2b done spacing", cyc, 11);
        if (got) pop_check("b2b second dout");
        else sb_q.delete();
        chk_int("b2b dout stable", unstable, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a run discards it.
        launch(CK, CD, CE);
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun reset busy", {127'd0, busy}, '0);
        chk("midrun reset done", {127'd0, done}, '0);
        chk("midrun reset dout", dout, '0);
        #1 rst = 1'b0;
        sb_q.delete();
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk_int("done after reset", cnt, 0);
        launch(BK, BD, BE);
        wait_done("post-reset B", 11, 10);

        // Random blocks: reference model, then inverse-cipher round trip.
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            model_enc(k, d, e);
            launch(k, d, e);
            wait_done($sformatf("rand%0d", n), 11, 10);
            model_dec(k, dout, rt);
            chk($sformatf("rand%0d roundtrip", n), rt, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
